// File: rtl/sequential_divider.sv
// ---------------------------------------------------------------------------
// sequential_divider
//   Multi-cycle unsigned restoring divider. One quotient bit is resolved per
//   clock, MSB first, so a division with a non-zero divisor takes WIDTH
//   cycles; a zero divisor is answered in a single cycle.
//
// Handshake: a request is accepted on a rising clk edge where start=1 and the
//   block is idle (busy=0). While busy=1, start is ignored. Results are valid
//   for exactly the one cycle in which done=1, and the result outputs keep
//   their values afterwards until the next completion or reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only while idle
//   dividend     unsigned numerator, captured on accepted start
//   divisor      unsigned denominator, captured on accepted start
//   busy         high while a division is in progress
//   done         single-cycle pulse, results valid
//   quotient     unsigned quotient (all ones on divide by zero)
//   remainder    unsigned remainder (dividend on divide by zero)
//   div_by_zero  high with results when the captured divisor was zero
// ---------------------------------------------------------------------------
module sequential_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ZERO = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;   // shifts left; MSB is the next bit
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [WIDTH:0]   partial_q, partial_d;     // one extra bit holds the trial sign
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   // One restoring step. The partial remainder is always below the divisor,
   // so the shifted value fits in WIDTH+1 bits and the trial's MSB is a
   // reliable sign bit.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             q_bit;
   logic [WIDTH:0]   next_partial;
   logic [WIDTH-1:0] next_quot;

   always_comb begin
      shifted      = {partial_q[WIDTH-1:0], dividend_q[WIDTH-1]};
      trial        = shifted - {1'b0, divisor_q};
      q_bit        = ~trial[WIDTH];
      next_partial = q_bit ? trial : shifted;
      next_quot    = {quot_q[WIDTH-2:0], q_bit};
   end

   always_comb begin
      state_d     = state_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      partial_d   = partial_q;
      quot_d      = quot_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               dividend_d = dividend;
               divisor_d  = divisor;
               partial_d  = '0;
               quot_d     = '0;
               count_d    = CW'(WIDTH);
               state_d    = (divisor == '0) ? ZERO : CALC;
            end
         end
         CALC: begin
            partial_d  = next_partial;
            quot_d     = next_quot;
            dividend_d = dividend_q << 1;
            count_d    = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               quotient_d  = next_quot;
               remainder_d = next_partial[WIDTH-1:0];
               dbz_d       = 1'b0;
               done_d      = 1'b1;
               state_d     = IDLE;
            end
         end
         ZERO: begin
            quotient_d  = '1;
            remainder_d = dividend_q;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         dividend_q  <= '0;
         divisor_q   <= '0;
         partial_q   <= '0;
         quot_q      <= '0;
         count_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         partial_q   <= partial_d;
         quot_q      <= quot_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         done_q      <= done_d;
      end
   end

   // The block is back in IDLE during the done cycle, so busy and done are
   // never high together.
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// ---------------------------------------------------------------------------
// tb_sequential_divider
//   Self-checking bench for sequential_divider at WIDTH=4. Expected results
//   {div_by_zero, quotient, remainder} are pushed to exp_q when a start is
//   driven that the DUT will accept, and popped when done is observed.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_sequential_divider;

   localparam int W = 4;
   localparam int TIMEOUT = 100;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   logic [2*W:0] exp_q[$];
   logic [2*W:0] exp_v;
   logic [2*W:0] got_v;

   int n_checks;
   int n_pass;
   int done_count;

   sequential_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts done pulses, sampled mid-cycle.
   initial done_count = 0;
   always @(negedge clk) begin
      if (done === 1'b1) done_count++;
   end

   // ---------------- reference model ----------------
   function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q;
      logic [W-1:0] r;
      if (b == 0) begin
         return {1'b1, {W{1'b1}}, a};
      end
      q = a / b;
      r = a % b;
      return {1'b0, q, r};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Drives a start that will be accepted at the next edge and records it.
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      exp_q.push_back(ref_div(a, b));
   endtask

   // Waits until done is seen (sampled after an edge); cycles counts edges.
   task automatic wait_done(output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         step();
         cycles++;
         if (done === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic pop_expected(output logic [2*W:0] v, output bit ok);
      ok = (exp_q.size() != 0);
      v  = ok ? exp_q.pop_front() : '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      #2 rst = 1'b1;
      #1;
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if ({busy, done, got_v} !== '0) $display("FAIL reset_outputs busy=%b done=%b dbz/q/r=%b required all zero", busy, done, got_v);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      step();
      n_checks++;
      if ({busy, done} !== 2'b00) $display("FAIL reset_idle busy=%b done=%b required 0 0", busy, done);
      else n_pass++;
   endtask

   task automatic test_basic;
      bit ok;
      int busy_cycles;
      drive_start(4'd13, 4'd3);
      step();                           // edge N
      start = 1'b0;
      busy_cycles = 0;
      for (int i = 1; i <= W; i++) begin
         if (busy === 1'b1) busy_cycles++;
         n_checks++;
         if (done !== 1'b0) $display("FAIL basic_early_done cycle %0d done=%b required 0", i, done);
         else n_pass++;
         step();                        // edge N+i
      end
      n_checks++;
      if (busy_cycles != W) $display("FAIL basic_busy_len got %0d required %0d", busy_cycles, W);
      else n_pass++;
      n_checks++;
      if ({done, busy} !== 2'b10) $display("FAIL basic_done_at_N+W done=%b busy=%b required 1 0", done, busy);
      else n_pass++;
      pop_expected(exp_v, ok);
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if (!ok || got_v !== exp_v) $display("FAIL basic_13_3 got %b required %b", got_v, exp_v);
      else n_pass++;
      step();
      n_checks++;
      if (done !== 1'b0 || got_v !== {div_by_zero, quotient, remainder})
         $display("FAIL basic_pulse_hold done=%b dbz/q/r=%b required 0 %b", done, {div_by_zero, quotient, remainder}, got_v);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      bit ok;
      int cyc;
      drive_start(4'd15, 4'd1);
      step();
      dividend = 4'd2;                  // held with start during the busy phase
      divisor  = 4'd3;
      wait_done(cyc, ok);
      n_checks++;
      if (!ok) $display("FAIL b2b_first_timeout no done within %0d cycles", TIMEOUT);
      else n_pass++;
      pop_expected(exp_v, ok);
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if (!ok || got_v !== exp_v) $display("FAIL b2b_15_1 got %b required %b", got_v, exp_v);
      else n_pass++;
      exp_q.push_back(ref_div(4'd2, 4'd3)); // start still high in the done cycle
      step();
      start = 1'b0;
      wait_done(cyc, ok);
      n_checks++;
      if (!ok || cyc + 1 != W + 1) $display("FAIL b2b_gap got %0d cycles required %0d", cyc + 1, W + 1);
      else n_pass++;
      pop_expected(exp_v, ok);
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if (!ok || got_v !== exp_v) $display("FAIL b2b_2_3 got %b required %b", got_v, exp_v);
      else n_pass++;
      step();
   endtask

   task automatic test_div_zero;
      bit ok;
      int cyc;
      drive_start(4'd9, 4'd0);
      step();
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL dbz_busy busy=%b required 1", busy);
      else n_pass++;
      wait_done(cyc, ok);
      n_checks++;
      if (!ok || cyc != 1) $display("FAIL dbz_latency got %0d required 1", cyc);
      else n_pass++;
      pop_expected(exp_v, ok);
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if (!ok || got_v !== exp_v) $display("FAIL dbz_9_0 got %b required %b", got_v, exp_v);
      else n_pass++;
      drive_start(4'd6, 4'd2);
      step();
      start = 1'b0;
      wait_done(cyc, ok);
      pop_expected(exp_v, ok);
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if (!ok || got_v !== exp_v) $display("FAIL dbz_then_6_2 got %b required %b", got_v, exp_v);
      else n_pass++;
      step();
   endtask

   task automatic test_ignore_start;
      bit ok;
      int base;
      int cyc;
      base = done_count;
      drive_start(4'd12, 4'd5);
      step();
      start = 1'b0;
      step();
      step();
      start = 1'b1;                     // arrives while busy: must be ignored
      dividend = 4'd7;
      divisor  = 4'd2;
      step();
      start = 1'b0;
      wait_done(cyc, ok);
      pop_expected(exp_v, ok);
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if (!ok || got_v !== exp_v) $display("FAIL ignore_12_5 got %b required %b", got_v, exp_v);
      else n_pass++;
      repeat (10) step();
      n_checks++;
      if (done_count - base != 1) $display("FAIL ignore_done_count got %0d required 1", done_count - base);
      else n_pass++;
   endtask

   task automatic test_async_reset;
      bit ok;
      int base;
      int cyc;
      start = 1'b1; dividend = 4'd14; divisor = 4'd3;  // aborted, never expected
      step();
      start = 1'b0;
      step();
      #3 rst = 1'b1;                    // between edges
      #1;
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if ({busy, done, got_v} !== '0) $display("FAIL async_reset busy=%b done=%b dbz/q/r=%b required all zero", busy, done, got_v);
      else n_pass++;
      base = done_count;
      @(negedge clk) rst = 1'b0;
      repeat (8) step();
      n_checks++;
      if (done_count != base || busy !== 1'b0) $display("FAIL async_no_done dones=%0d busy=%b required 0 0", done_count - base, busy);
      else n_pass++;
      drive_start(4'd14, 4'd3);
      step();
      start = 1'b0;
      wait_done(cyc, ok);
      pop_expected(exp_v, ok);
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if (!ok || got_v !== exp_v) $display("FAIL async_then_14_3 got %b required %b", got_v, exp_v);
      else n_pass++;
      step();
   endtask

   task automatic run_sweep_op(input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok;
      int cyc;
      drive_start(a, b);
      step();
      start = 1'b0;
      wait_done(cyc, ok);
      n_checks++;
      if (!ok || cyc != ((b == 0) ? 1 : W)) $display("FAIL sweep_latency %0d/%0d got %0d", a, b, cyc);
      else n_pass++;
      pop_expected(exp_v, ok);
      got_v = {div_by_zero, quotient, remainder};
      n_checks++;
      if (!ok || got_v !== exp_v) $display("FAIL sweep_%0d_%0d got %b required %b", a, b, got_v, exp_v);
      else n_pass++;
   endtask

   task automatic test_sweep;
      for (int a = 0; a < (1 << W); a++) begin
         for (int b = 0; b < (1 << W); b++) begin
            run_sweep_op(W'(a), W'(b));
         end
      end
      for (int k = 0; k < 20; k++) begin
         run_sweep_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)));
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain %0d entries left required 0", exp_q.size());
      else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_ignore_start();
      test_async_reset();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
